neuron_layer_scheduler: RTL

NEURON_LAYER_SCHEDULER -- requirements
Module: neuron_layer_scheduler

---
 rtl/neuron_sched_pkg.sv | 16 +
 rtl/sched_watchdog.sv | 24 ++
 rtl/neuron_layer_scheduler.sv | 133 +++++++++++++
 3 files changed

// File: rtl/neuron_sched_pkg.sv
// Shared types and defaults for the time-multiplexed neuron layer scheduler.
package neuron_sched_pkg;
    localparam int DEF_NUM_INPUTS  = 2;
    localparam int DEF_NUM_OUTPUTS = 4;
    localparam int DEF_WIDTH       = 8;
    localparam int DEF_TIMEOUT     = 64;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_LOAD, ST_SEND, ST_GAP, ST_WAIT, ST_DONE
    } sched_state_t;

    // Index width for a count of n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sched_watchdog.sv
// WAIT-state watchdog: counts enabled cycles since the last clear and flags
// the TIMEOUT-th one.
module sched_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST || clear)
            cnt <= '0;
        else if (enable && !expired)
            cnt <= cnt + 1'b1;
    end

    assign expired = enable && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/neuron_layer_scheduler.sv
// Sequences one input vector through NUM_OUTPUTS neurons sharing a single
// neuron datapath: fetch parameters, stream inputs, collect each result.
module neuron_layer_scheduler
    import neuron_sched_pkg::*;
#(
    parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
    parameter int NUM_OUTPUTS = DEF_NUM_OUTPUTS,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [NUM_INPUTS*WIDTH-1:0]       IN_VALUES,
    input  logic                              IN_VALID,
    output logic                              IN_READY,
    output logic                              WGT_RD_EN,
    output logic [idx_w(NUM_OUTPUTS)-1:0]     WGT_ADDR,
    input  logic [(NUM_INPUTS+1)*WIDTH-1:0]   WGT_RD_DATA,
    output logic [NUM_INPUTS*WIDTH-1:0]       NRN_WEIGHTS,
    output logic [WIDTH-1:0]                  NRN_BIAS,
    output logic [WIDTH-1:0]                  NRN_VALUE_IN,
    output logic                              NRN_VALID_IN,
    input  logic                              NRN_READY,
    input  logic [WIDTH-1:0]                  NRN_VALUE_OUT,
    input  logic                              NRN_VALID_OUT,
    input  logic                              NRN_OVERFLOW,
    output logic [NUM_OUTPUTS*WIDTH-1:0]      OUT_VALUES,
    output logic [NUM_OUTPUTS-1:0]            OUT_OVERFLOW,
    output logic                              OUT_VALID,
    input  logic                              OUT_READY,
    output logic                              ERROR
);
    localparam int AW = idx_w(NUM_OUTPUTS);
    localparam int IW = idx_w(NUM_INPUTS);
    localparam logic [AW-1:0] LAST_J = AW'(NUM_OUTPUTS - 1);
    localparam logic [IW-1:0] LAST_I = IW'(NUM_INPUTS - 1);

    sched_state_t                          state;
    logic [NUM_INPUTS-1:0][WIDTH-1:0]      x_q;
    logic [NUM_OUTPUTS-1:0][WIDTH-1:0]     out_q;
    logic [AW-1:0]                         j;
    logic [IW-1:0]                         i;
    logic                                  wd_expired;

    sched_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (state != ST_WAIT),
        .enable  (state == ST_WAIT),
        .expired (wd_expired)
    );

    // The pulse is qualified by READY combinationally so it lands in the very
    // cycle READY is sampled; GAP then guarantees a dead cycle after it.
    assign NRN_VALID_IN = (state == ST_SEND) && NRN_READY;
    assign NRN_VALUE_IN = (state == ST_SEND) ? x_q[i] : '0;
    assign OUT_VALUES   = out_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= ST_IDLE;
            IN_READY     <= 1'b1;
            OUT_VALID    <= 1'b0;
            WGT_RD_EN    <= 1'b0;
            WGT_ADDR     <= '0;
            NRN_WEIGHTS  <= '0;
            NRN_BIAS     <= '0;
            out_q        <= '0;
            OUT_OVERFLOW <= '0;
            ERROR        <= 1'b0;
            x_q          <= '0;
            j            <= '0;
            i            <= '0;
        end else begin
            WGT_RD_EN <= 1'b0;
            case (state)
                ST_IDLE: if (IN_VALID) begin
                    x_q          <= IN_VALUES;
                    out_q        <= '0;
                    OUT_OVERFLOW <= '0;
                    ERROR        <= 1'b0;
                    j            <= '0;
                    IN_READY     <= 1'b0;
                    WGT_RD_EN    <= 1'b1;
                    WGT_ADDR     <= '0;
                    state        <= ST_FETCH;
                end
                ST_FETCH: state <= ST_LOAD;
                ST_LOAD: begin
                    NRN_WEIGHTS <= WGT_RD_DATA[NUM_INPUTS*WIDTH-1:0];
                    NRN_BIAS    <= WGT_RD_DATA[(NUM_INPUTS+1)*WIDTH-1 -: WIDTH];
                    i           <= '0;
                    state       <= ST_SEND;
                end
                ST_SEND: if (NRN_READY) begin
                    if (i == LAST_I) begin
                        state <= ST_WAIT;
                    end else begin
                        i     <= i + 1'b1;
                        state <= ST_GAP;
                    end
                end
                ST_GAP: state <= ST_SEND;
                ST_WAIT: begin
                    // A result arriving on the expiry cycle still wins.
                    if (NRN_VALID_OUT) begin
                        out_q[j]        <= NRN_VALUE_OUT;
                        OUT_OVERFLOW[j] <= NRN_OVERFLOW;
                        if (j == LAST_J) begin
                            OUT_VALID <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            j         <= j + 1'b1;
                            WGT_RD_EN <= 1'b1;
                            WGT_ADDR  <= j + 1'b1;
                            state     <= ST_FETCH;
                        end
                    end else if (wd_expired) begin
                        ERROR     <= 1'b1;
                        OUT_VALID <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: if (OUT_READY) begin
                    OUT_VALID <= 1'b0;
                    IN_READY  <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
